// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the packed-RGB stream sink.
//   - default frame geometry and the words-per-line it implies
//   - byte lanes of b/g/r within one unpacked pixel
//   - framing FSM state encodings
//   - bit positions of the sticky error flags
package pixel_stream_pkg;

    localparam int DEF_X_SIZE = 1280;
    localparam int DEF_Y_SIZE = 720;
    localparam int DEF_WPL    = (DEF_X_SIZE * 3) / 4;

    // Counter widths sized for the default geometry.
    localparam int X_W    = 11;
    localparam int Y_W    = 10;
    localparam int WCNT_W = 11;

    // Each pixel arrives as three consecutive bytes: b, g, r.
    localparam int B_LANE = 0;
    localparam int G_LANE = 1;
    localparam int R_LANE = 2;

    localparam int ACC_DEPTH  = 6;
    localparam int PUSH_BYTES = 4;
    localparam int POP_BYTES  = 3;

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam int ERR_SOF_EARLY = 0;
    localparam int ERR_SOF_LATE  = 1;
    localparam int ERR_EOL_EARLY = 2;
    localparam int ERR_EOL_LATE  = 3;
    localparam int ERR_COUNT     = 4;

endpackage

// File: rtl/pixel_byte_accum.sv
// Six-byte accumulator: accepts one 32-bit word (4 bytes) and releases one
// 3-byte pixel from the head. Byte 0 of the register array is the head.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   flush        discard all buffered bytes (a simultaneous push is kept)
//   push, din    append the 4 bytes of din, little-endian
//   pop          drop the 3 head bytes
//   cnt          current occupancy, 0..6
//   head         3 head bytes, byte k at head[8k+7:8k]
module pixel_byte_accum
    import pixel_stream_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [2:0]  cnt,
    output logic [23:0] head
);

    logic [7:0] byte_q [ACC_DEPTH];
    logic [7:0] byte_d [ACC_DEPTH];
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic [2:0] base;

    always_comb begin
        byte_d = byte_q;
        cnt_d  = cnt_q;
        base   = cnt_q;
        if (flush) begin
            base  = 3'd0;
            cnt_d = 3'd0;
        end else if (pop) begin
            for (int i = 0; i < ACC_DEPTH - POP_BYTES; i++) begin
                byte_d[i] = byte_q[i + POP_BYTES];
            end
            base  = cnt_q - 3'd3;
            cnt_d = cnt_q - 3'd3;
        end
        // New bytes land right after whatever survives the pop/flush.
        if (push) begin
            for (int i = 0; i < ACC_DEPTH; i++) begin
                for (int k = 0; k < PUSH_BYTES; k++) begin
                    if ({1'b0, base} + 4'(k) == 4'(i)) begin
                        byte_d[i] = din[8*k +: 8];
                    end
                end
            end
            cnt_d = cnt_d + 3'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 3'd0;
            for (int i = 0; i < ACC_DEPTH; i++) begin
                byte_q[i] <= 8'h00;
            end
        end else begin
            cnt_q  <= cnt_d;
            byte_q <= byte_d;
        end
    end

    assign cnt  = cnt_q;
    assign head = {byte_q[2], byte_q[1], byte_q[0]};

endmodule

// File: rtl/pixel_unpacker.sv
// AXI4-Stream packed-RGB sink: unpacks 32-bit words (tuser = SOF,
// tlast = EOL) into one 24-bit pixel per handshake with x/y position,
// checks frame geometry and resynchronises on framing errors.
// Ports:
//   in_stream_aclk, periph_reset        clock, asynchronous active-high reset
//   in_stream_t*                        input stream (tkeep ignored)
//   r, g, b, pix_valid, pix_ready       pixel output handshake
//   x, y, sof, eol                      position and frame/line markers
//   err_*                               sticky framing errors, cleared by clr_err
//   frame_count                         complete error-free frames, wraps
//
// state  | meaning
// SYNC   | discarding words until one carries tuser
// ACTIVE | inside a frame, unpacking and checking geometry
module pixel_unpacker
    import pixel_stream_pkg::*;
#(
    parameter int X_SIZE     = DEF_X_SIZE,
    parameter int Y_SIZE     = DEF_Y_SIZE,
    parameter int FCNT_WIDTH = 16
)(
    input  logic                  in_stream_aclk,
    input  logic                  periph_reset,
    input  logic [31:0]           in_stream_tdata,
    input  logic [3:0]            in_stream_tkeep,
    input  logic                  in_stream_tlast,
    input  logic                  in_stream_tuser,
    input  logic                  in_stream_tvalid,
    output logic                  in_stream_tready,
    output logic [7:0]            r,
    output logic [7:0]            g,
    output logic [7:0]            b,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [X_W-1:0]        x,
    output logic [Y_W-1:0]        y,
    output logic                  sof,
    output logic                  eol,
    output logic                  err_sof_early,
    output logic                  err_sof_late,
    output logic                  err_eol_early,
    output logic                  err_eol_late,
    input  logic                  clr_err,
    output logic [FCNT_WIDTH-1:0] frame_count
);

    localparam int WPL = (X_SIZE * 3) / 4;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WPL - 1);
    localparam logic [Y_W-1:0]    LCNT_LAST = Y_W'(Y_SIZE - 1);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(X_SIZE - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(Y_SIZE - 1);

    state_t                state_q;
    state_t                state_d;
    logic                  rdy_en_q;
    logic [2:0]            cnt;
    logic [23:0]           head;
    logic [WCNT_W-1:0]     wcnt_q;
    logic [Y_W-1:0]        lcnt_q;
    logic [X_W-1:0]        x_q;
    logic [Y_W-1:0]        y_q;
    logic [ERR_COUNT-1:0]  err_q;
    logic [ERR_COUNT-1:0]  err_set;
    logic [FCNT_WIDTH-1:0] fcnt_q;
    logic                  accept;
    logic                  pop;
    logic                  flush;
    logic                  push;
    logic                  frame_start;
    logic                  word_adv;
    logic                  at_frame_start;
    logic                  chk_sof_early;
    logic                  chk_sof_late;
    logic                  chk_eol_early;
    logic                  chk_eol_late;
    logic                  tkeep_unused;

    assign tkeep_unused = ^in_stream_tkeep;

    // tready stays low for the first cycle after reset so that it reads 0
    // throughout reset even though SYNC otherwise accepts unconditionally.
    always_ff @(posedge in_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    // ready and valid are mutually exclusive in ACTIVE, so a word is only
    // ever taken when fewer than one whole pixel is buffered.
    assign in_stream_tready = (state_q == ST_SYNC) ? rdy_en_q : (cnt < 3'd3);
    assign pix_valid        = (state_q == ST_ACTIVE) && (cnt >= 3'd3);
    assign accept           = in_stream_tvalid & in_stream_tready;
    assign pop              = pix_valid & pix_ready;

    assign at_frame_start = (wcnt_q == '0) && (lcnt_q == '0);
    assign chk_sof_early  = in_stream_tuser & ~at_frame_start;
    assign chk_sof_late   = ~in_stream_tuser & at_frame_start;
    assign chk_eol_early  = in_stream_tlast & (wcnt_q != WCNT_LAST);
    assign chk_eol_late   = ~in_stream_tlast & (wcnt_q == WCNT_LAST);

    always_ff @(posedge in_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC: begin
                if (accept && in_stream_tuser) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // An early SOF restarts in place; every other error resyncs.
                if (accept && !chk_sof_early &&
                    (chk_sof_late || chk_eol_early || chk_eol_late)) begin
                    state_d = ST_SYNC;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_comb begin
        push        = 1'b0;
        flush       = 1'b0;
        frame_start = 1'b0;
        word_adv    = 1'b0;
        err_set     = '0;
        case (state_q)
            ST_SYNC: begin
                if (accept && in_stream_tuser) begin
                    flush       = 1'b1;
                    push        = 1'b1;
                    frame_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (accept) begin
                    if (chk_sof_early) begin
                        err_set[ERR_SOF_EARLY] = 1'b1;
                        flush       = 1'b1;
                        push        = 1'b1;
                        frame_start = 1'b1;
                    end else if (chk_sof_late) begin
                        err_set[ERR_SOF_LATE] = 1'b1;
                        flush = 1'b1;
                    end else if (chk_eol_early) begin
                        err_set[ERR_EOL_EARLY] = 1'b1;
                        flush = 1'b1;
                    end else if (chk_eol_late) begin
                        err_set[ERR_EOL_LATE] = 1'b1;
                        flush = 1'b1;
                    end else begin
                        push     = 1'b1;
                        word_adv = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    pixel_byte_accum u_accum (
        .clk   (in_stream_aclk),
        .rst   (periph_reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (in_stream_tdata),
        .cnt   (cnt),
        .head  (head)
    );

    always_ff @(posedge in_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            wcnt_q <= '0;
            lcnt_q <= '0;
        end else if (frame_start) begin
            // The SOF word itself is word 0, so the next expected is word 1.
            wcnt_q <= WCNT_W'(1);
            lcnt_q <= '0;
        end else if (word_adv) begin
            if (wcnt_q == WCNT_LAST) begin
                wcnt_q <= '0;
                lcnt_q <= (lcnt_q == LCNT_LAST) ? '0 : lcnt_q + 1'b1;
            end else begin
                wcnt_q <= wcnt_q + 1'b1;
            end
        end else if (flush) begin
            wcnt_q <= '0;
            lcnt_q <= '0;
        end
    end

    always_ff @(posedge in_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            x_q <= '0;
            y_q <= '0;
        end else if (frame_start) begin
            x_q <= '0;
            y_q <= '0;
        end else if (pop) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    // Any error flushes the accumulator and resets position, so the last
    // pixel of a frame can only be emitted if the frame ran clean from SOF.
    always_ff @(posedge in_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            fcnt_q <= '0;
        end else if (pop && (x_q == X_LAST) && (y_q == Y_LAST)) begin
            fcnt_q <= fcnt_q + 1'b1;
        end
    end

    // A new error in the same cycle as clr_err keeps its flag set.
    always_ff @(posedge in_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            err_q <= '0;
        end else begin
            err_q <= (err_q & ~{ERR_COUNT{clr_err}}) | err_set;
        end
    end

    assign r             = head[8*R_LANE +: 8];
    assign g             = head[8*G_LANE +: 8];
    assign b             = head[8*B_LANE +: 8];
    assign x             = x_q;
    assign y             = y_q;
    assign sof           = pix_valid && (x_q == '0) && (y_q == '0);
    assign eol           = pix_valid && (x_q == X_LAST);
    assign err_sof_early = err_q[ERR_SOF_EARLY];
    assign err_sof_late  = err_q[ERR_SOF_LATE];
    assign err_eol_early = err_q[ERR_EOL_EARLY];
    assign err_eol_late  = err_q[ERR_EOL_LATE];
    assign frame_count   = fcnt_q;

endmodule

// File: tb/tb_pixel_unpacker.sv
module tb_pixel_unpacker;

    localparam int XS  = 8;
    localparam int YS  = 4;
    localparam int WPL = XS * 3 / 4;
    localparam int FW  = WPL * YS;

    typedef struct {
        logic [23:0] rgb;
        int          px;
        int          py;
        logic        psof;
        logic        peol;
    } pix_t;

    typedef struct {
        logic [31:0] data;
        logic        user;
        logic        last;
    } wvec_t;

    logic        clk;
    logic        rst;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;
    logic [7:0]  r, g, b;
    logic        pix_valid;
    logic        pix_ready;
    logic [10:0] x;
    logic [9:0]  y;
    logic        sof, eol;
    logic        e_se, e_sl, e_ee, e_el;
    logic        clr_err;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 0;   // 0 high, 1 random, 2 low

    pix_t        exp_q[$];
    logic [7:0]  bq[$];
    int          mx = 0;
    int          my = 0;
    pix_t        mon_e;
    wvec_t       wtab[3];
    pix_t        ptab[4];
    logic [31:0] d;

    pixel_unpacker #(.X_SIZE(XS), .Y_SIZE(YS), .FCNT_WIDTH(16)) dut (
        .in_stream_aclk   (clk),
        .periph_reset     (rst),
        .in_stream_tdata  (tdata),
        .in_stream_tkeep  (tkeep),
        .in_stream_tlast  (tlast),
        .in_stream_tuser  (tuser),
        .in_stream_tvalid (tvalid),
        .in_stream_tready (tready),
        .r                (r),
        .g                (g),
        .b                (b),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .x                (x),
        .y                (y),
        .sof              (sof),
        .eol              (eol),
        .err_sof_early    (e_se),
        .err_sof_late     (e_sl),
        .err_eol_early    (e_ee),
        .err_eol_late     (e_el),
        .clr_err          (clr_err),
        .frame_count      (frame_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        pix_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = 1'($urandom_range(0, 1));
                default: pix_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] errs();
        return {e_el, e_ee, e_sl, e_se};
    endfunction

    // Reference: bytes in arrival order, every 3 bytes form b,g,r.
    task automatic model_push(input logic [31:0] w);
        logic [7:0] pb, pg, pr;
        for (int k = 0; k < 4; k++) bq.push_back(w[8*k +: 8]);
        while (bq.size() >= 3) begin
            pb = bq.pop_front();
            pg = bq.pop_front();
            pr = bq.pop_front();
            exp_q.push_back('{{pr, pg, pb}, mx, my, (mx == 0 && my == 0), (mx == XS - 1)});
            if (mx == XS - 1) begin
                mx = 0;
                my = (my == YS - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
    endtask

    task automatic model_frame_start();
        bq.delete();
        mx = 0;
        my = 0;
    endtask

    always @(negedge clk) begin
        if (!rst && pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pixel: got rgb 0x%0h x %0d y %0d, expected none", {r, g, b}, x, y);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pix_rgb", {8'h0, r, g, b}, {8'h0, mon_e.rgb});
                chk("pix_x", 32'(x), mon_e.px);
                chk("pix_y", 32'(y), mon_e.py);
                chk("pix_sof", 32'(sof), 32'(mon_e.psof));
                chk("pix_eol", 32'(eol), 32'(mon_e.peol));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_word(input logic [31:0] w, input logic u, input logic l,
                             input logic keep, input logic clr);
        int n = 0;
        tdata  = w;
        tuser  = u;
        tlast  = l;
        tvalid = 1'b1;
        while (!tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!tready) begin
            chk("tready_wait", 32'(n), 32'(199));
            tvalid = 1'b0;
            return;
        end
        clr_err = clr;
        if (keep) model_push(w);
        @(negedge clk);
        tvalid  = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic send_range(input int w0, input int w1);
        for (int w = w0; w <= w1; w++) begin
            send_word($urandom, (w == 0), ((w % WPL) == WPL - 1), 1'b1, 1'b0);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 32'(exp_q.size()), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        chk("clr_err_clears", 32'(errs()), 0);
    endtask

    initial begin
        rst = 1; tdata = 0; tkeep = 4'hF; tlast = 0; tuser = 0; tvalid = 0; clr_err = 0;

        wtab[0] = '{32'h44332211, 1'b1, 1'b0};
        wtab[1] = '{32'h88776655, 1'b0, 1'b0};
        wtab[2] = '{32'hCCBBAA99, 1'b0, 1'b0};
        ptab[0] = '{24'h332211, 0, 0, 1'b1, 1'b0};
        ptab[1] = '{24'h665544, 1, 0, 1'b0, 1'b0};
        ptab[2] = '{24'h998877, 2, 0, 1'b0, 1'b0};
        ptab[3] = '{24'hCCBBAA, 3, 0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tready", 32'(tready), 0);
        chk("rst_pix_valid", 32'(pix_valid), 0);
        chk("rst_rgb", {8'h0, r, g, b}, 0);
        chk("rst_xy", {x, y}, 0);
        chk("rst_sof_eol", {sof, eol}, 0);
        chk("rst_errs", 32'(errs()), 0);
        chk("rst_fcnt", 32'(frame_count), 0);
        rst = 0;
        repeat (2) @(negedge clk);
        chk("sync_tready", 32'(tready), 1);

        // Hand-computed first group, then finish the frame from the model
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back(ptab[i]);
        for (int i = 0; i < 3; i++) begin
            send_word(wtab[i].data, wtab[i].user, wtab[i].last, 1'b0, 1'b0);
            if (i == 0) begin
                chk("first_pix_latency", 32'(pix_valid), 1);
                chk("tready_when_full", 32'(tready), 0);
            end
        end
        bq.delete(); mx = 4; my = 0;
        send_range(3, FW - 1);
        drain();
        chk("fcnt_frame1", 32'(frame_count), 1);
        chk("errs_frame1", 32'(errs()), 0);

        // Random data with pix_ready toggling
        rdy_mode = 1;
        model_frame_start();
        send_range(0, FW - 1);
        drain();
        chk("fcnt_frame2", 32'(frame_count), 2);

        // Early EOL on word 2 of line 1, following words dropped
        model_frame_start();
        send_range(0, WPL + 1);
        send_word($urandom, 1'b0, 1'b1, 1'b0, 1'b0);
        bq.delete();
        chk("eol_early_flag", 32'(errs()), 32'b0100);
        chk("eol_early_flush", 32'(pix_valid), 0);
        for (int i = 0; i < 3; i++) send_word($urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        pulse_clr();
        model_frame_start();
        send_range(0, FW - 1);
        drain();
        chk("fcnt_after_resync", 32'(frame_count), 3);

        // Missing SOF where a new frame is expected
        send_word($urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sof_late_flag", 32'(errs()), 32'b0010);
        pulse_clr();

        // Missing EOL on the last word of line 0
        model_frame_start();
        send_range(0, WPL - 2);
        send_word($urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        bq.delete();
        chk("eol_late_flag", 32'(errs()), 32'b1000);
        drain();
        pulse_clr();

        // SOF+EOL mid-line: only sof_early, even with clr_err in the same cycle
        rdy_mode = 0;
        model_frame_start();
        send_range(0, 1);
        drain();
        model_frame_start();
        send_word($urandom, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("sof_early_prio", 32'(errs()), 32'b0001);
        chk("fcnt_after_restart", 32'(frame_count), 3);
        d = $urandom;
        send_word(d, 1'b0, 1'b0, 1'b1, 1'b0);
        rdy_mode  = 2;
        pix_ready = 1'b0;
        chk("cnt5_pix_valid", 32'(pix_valid), 1);
        chk("cnt5_tready", 32'(tready), 0);

        // Mid-line reset
        rst = 1;
        #1;
        chk("midrst_pix_valid", 32'(pix_valid), 0);
        chk("midrst_tready", 32'(tready), 0);
        chk("midrst_errs", 32'(errs()), 0);
        chk("midrst_fcnt", 32'(frame_count), 0);
        exp_q.delete();
        bq.delete();
        repeat (3) @(negedge clk);
        rst = 0;
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        chk("post_rst_sync", {31'h0, tready}, 1);

        // Words before the first SOF are dropped
        for (int i = 0; i < 5; i++) send_word($urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("drop_no_pixel", 32'(pix_valid), 0);
        model_frame_start();
        send_range(0, FW - 1);
        drain();
        chk("fcnt_post_rst", 32'(frame_count), 1);
        chk("errs_post_rst", 32'(errs()), 0);
        chk("exp_queue_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
